// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: widths, opcodes,
// FSM states and the constant-distance shift helper used by the datapath.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int K_W     = 6;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // sh is always an elaboration constant (1..32) at the call sites, so this
    // folds to plain wiring per opcode; sh == 32 is well defined for all ops.
    function automatic logic [DATA_W-1:0] shift_by(
        input logic [DATA_W-1:0] x,
        input logic [1:0]        op,
        input int                sh
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $signed(x) >>> sh;
            default: r = (x >> sh) | (x << (DATA_W - sh));
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Request/response handshake bundle between the ALU decode stage (master)
// and the shift sequencer (slave).
interface shift_ctrl_if;
    import shift_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [SHAMT_W-1:0]  shamt;
    logic [1:0]          op;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                busy;

    modport master (
        output in_valid, in_data, shamt, op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, shamt, op, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_step.sv
// Combinational shift of acc by k positions (0..32) for one of SLL/SRL/SRA/ROR,
// built as a log-depth stack of power-of-two stages.
module shift_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] acc_i,
    input  logic [K_W-1:0]    k_i,
    input  logic [1:0]        op_i,
    output logic [DATA_W-1:0] res_o
);

    logic [DATA_W-1:0] stage [0:K_W];

    assign stage[0] = acc_i;

    // Composing power-of-two stages is exact for every op, including SRA,
    // because each stage re-replicates the current bit 31.
    genvar gi;
    generate
        for (gi = 0; gi < K_W; gi++) begin : g_stage
            assign stage[gi+1] = k_i[gi] ? shift_by(stage[gi], op_i, 1 << gi)
                                         : stage[gi];
        end
    endgenerate

    assign res_o = stage[K_W];

endmodule

// File: rtl/shift_ctrl.sv
// Multi-cycle shift sequencer: accepts one request, shifts at most STEP
// positions per clock, then holds the result until the consumer takes it.
module shift_ctrl
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    shift_ctrl_if.slave   bus
);

    localparam logic [K_W-1:0] STEP_K = K_W'(STEP);

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;

    logic [K_W-1:0]       cnt_ext;
    logic [K_W-1:0]       k;
    logic [DATA_W-1:0]    step_res;

    assign cnt_ext = {1'b0, cnt_q};
    assign k       = (cnt_ext < STEP_K) ? cnt_ext : STEP_K;

    shift_step u_step (
        .acc_i (acc_q),
        .k_i   (k),
        .op_i  (op_q),
        .res_o (step_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    cnt_d   = bus.shamt;
                    op_d    = bus.op;
                    state_d = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // k never exceeds cnt, so the low bits carry the full step
                acc_d = step_res;
                cnt_d = cnt_q - k[SHAMT_W-1:0];
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: a vector table run on STEP=1 and STEP=4
// instances in parallel, plus hand-written backpressure and reset sequences.
module tb_shift_ctrl;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 15;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    shift_ctrl_if if1 ();
    shift_ctrl_if if4 ();

    shift_ctrl #(.STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    shift_ctrl #(.STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat1, lat4, exp1, exp4;
        logic [31:0] got1, got4;
        lat1 = 0; lat4 = 0; got1 = '0; got4 = '0;
        exp1 = 1 + int'(v.shamt);
        exp4 = 1 + (int'(v.shamt) + 3) / 4;
        @(negedge clk);
        check("idle_in_ready1", 32'(if1.in_ready), 32'd1);
        check("idle_in_ready4", 32'(if4.in_ready), 32'd1);
        if1.in_valid = 1'b1; if1.in_data = v.data; if1.shamt = v.shamt; if1.op = v.op; if1.out_ready = 1'b1;
        if4.in_valid = 1'b1; if4.in_data = v.data; if4.shamt = v.shamt; if4.op = v.op; if4.out_ready = 1'b1;
        @(negedge clk);
        // operands change after acceptance and must be ignored
        if1.in_valid = 1'b0; if1.in_data = ~v.data; if1.shamt = ~v.shamt; if1.op = ~v.op;
        if4.in_valid = 1'b0; if4.in_data = ~v.data; if4.shamt = ~v.shamt; if4.op = ~v.op;
        for (int c = 1; c <= 40; c++) begin
            if (lat1 == 0) begin
                check("busy1", 32'(if1.busy), 32'd1);
                if (if1.out_valid) begin
                    lat1 = c; got1 = if1.out_data;
                    check("data1", if1.out_data, v.exp);
                end
            end
            if (lat4 == 0) begin
                check("busy4", 32'(if4.busy), 32'd1);
                if (if4.out_valid) begin
                    lat4 = c; got4 = if4.out_data;
                    check("data4", if4.out_data, v.exp);
                end
            end
            if (lat1 != 0 && lat4 != 0) break;
            @(negedge clk);
        end
        check("latency1", 32'(lat1), 32'(exp1));
        check("latency4", 32'(lat4), 32'(exp4));
        $display("txn %0d: op=%0d data=0x%08h shamt=%0d -> step1 0x%08h lat %0d, step4 0x%08h lat %0d",
                 idx, v.op, v.data, v.shamt, got1, lat1, got4, lat4);
    endtask

    initial begin
        int c;
        logic seen;
        checks = 0;
        errors = 0;
        vecs[0]  = '{32'h00000001, 5'd5,  SLL, 32'h00000020};
        vecs[1]  = '{32'h80000000, 5'd9,  SRA, 32'hFFC00000};
        vecs[2]  = '{32'h00000001, 5'd1,  ROR, 32'h80000000};
        vecs[3]  = '{32'h12345678, 5'd0,  SRL, 32'h12345678};
        vecs[4]  = '{32'hF0000000, 5'd4,  SRL, 32'h0F000000};
        vecs[5]  = '{32'h80000000, 5'd31, SRL, 32'h00000001};
        vecs[6]  = '{32'h7FFFFFFF, 5'd31, SRA, 32'h00000000};
        vecs[7]  = '{32'h80000001, 5'd31, SRA, 32'hFFFFFFFF};
        vecs[8]  = '{32'h12345678, 5'd8,  ROR, 32'h78123456};
        vecs[9]  = '{32'h12345678, 5'd31, ROR, 32'h2468ACF0};
        vecs[10] = '{32'hFFFFFFFF, 5'd31, SLL, 32'h80000000};
        vecs[11] = '{32'hDEADBEEF, 5'd4,  SLL, 32'hEADBEEF0};
        vecs[12] = '{32'h80000000, 5'd3,  SRA, 32'hF0000000};
        vecs[13] = '{32'h0000ABCD, 5'd16, SLL, 32'hABCD0000};
        vecs[14] = '{32'h87654321, 5'd13, ROR, 32'h190C3B2A};

        if1.in_valid = 1'b0; if1.in_data = '0; if1.shamt = '0; if1.op = SLL; if1.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.shamt = '0; if4.op = SLL; if4.out_ready = 1'b0;

        // reset held for 3 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(if1.in_ready), 32'd1);
        check("rst_out_valid", 32'(if1.out_valid), 32'd0);
        check("rst_busy", 32'(if1.busy), 32'd0);
        check("rst_out_data", if1.out_data, 32'd0);
        check("rst_busy4", 32'(if4.busy), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // backpressure: SRL 0xF0000000 by 4, consumer stalls 5 cycles
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_data = 32'hF0000000; if1.shamt = 5'd4; if1.op = SRL; if1.out_ready = 1'b0;
        @(negedge clk);
        if1.in_valid = 1'b0;
        c = 1;
        while (!if1.out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("bp_latency", 32'(c), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(if1.out_valid), 32'd1);
            check("bp_out_data", if1.out_data, 32'h0F000000);
            check("bp_in_ready", 32'(if1.in_ready), 32'd0);
            @(negedge clk);
        end
        if1.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(if1.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(if1.out_valid), 32'd0);
        $display("txn bp: SRL 0xf0000000 by 4 held 5 cycles, latency %0d", c);

        // reset in C10 of a 31-position SLL
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_data = 32'h00000001; if1.shamt = 5'd31; if1.op = SLL; if1.out_ready = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        seen = 1'b0;
        for (int cc = 1; cc <= 10; cc++) begin
            seen = seen | if1.out_valid;
            if (cc < 10) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(if1.in_ready), 32'd1);
        check("midrst_out_valid", 32'(if1.out_valid), 32'd0);
        check("midrst_busy", 32'(if1.busy), 32'd0);
        check("midrst_out_data", if1.out_data, 32'd0);
        for (int cc = 0; cc < 40; cc++) begin
            @(negedge clk);
            seen = seen | if1.out_valid | if1.busy;
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);
        $display("txn midrst: SLL by 31 aborted in C10");

        // rst and in_valid together: reset wins
        @(negedge clk);
        rst = 1'b1;
        if1.in_valid = 1'b1; if1.in_data = 32'hA5A5A5A5; if1.shamt = 5'd3; if1.op = SRL;
        @(negedge clk);
        rst = 1'b0;
        if1.in_valid = 1'b0;
        check("rstwin_busy", 32'(if1.busy), 32'd0);
        check("rstwin_in_ready", 32'(if1.in_ready), 32'd1);
        @(negedge clk);
        check("rstwin_busy_later", 32'(if1.busy), 32'd0);
        $display("txn rstwin: request coincident with reset not accepted");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
